// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - ID/EX stage bundle: control, decoded ID fields and registered EX copies.
// master drives the ID side and observes EX; slave is the pipeline register itself.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  stall;
  logic                  flush;
  logic                  id_valid;
  logic                  id_regdst;
  logic                  id_branch;
  logic                  id_memtoreg;
  logic                  id_alusrc;
  logic                  id_regwrite;
  logic [1:0]            id_jump;
  logic [1:0]            id_aluop;
  logic [1:0]            id_memread;
  logic [1:0]            id_memwrite;
  logic [DATA_W-1:0]     id_pc4;
  logic [DATA_W-1:0]     id_rdata1;
  logic [DATA_W-1:0]     id_rdata2;
  logic [DATA_W-1:0]     id_imm;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;

  logic                  ex_valid;
  logic                  ex_regdst;
  logic                  ex_branch;
  logic                  ex_memtoreg;
  logic                  ex_alusrc;
  logic                  ex_regwrite;
  logic [1:0]            ex_jump;
  logic [1:0]            ex_aluop;
  logic [1:0]            ex_memread;
  logic [1:0]            ex_memwrite;
  logic [DATA_W-1:0]     ex_pc4;
  logic [DATA_W-1:0]     ex_rdata1;
  logic [DATA_W-1:0]     ex_rdata2;
  logic [DATA_W-1:0]     ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  load_use_stall;

  modport master (
    output stall, flush, id_valid, id_regdst, id_branch, id_memtoreg, id_alusrc, id_regwrite,
           id_jump, id_aluop, id_memread, id_memwrite, id_pc4, id_rdata1, id_rdata2, id_imm,
           id_rs, id_rt, id_rd,
    input  ex_valid, ex_regdst, ex_branch, ex_memtoreg, ex_alusrc, ex_regwrite,
           ex_jump, ex_aluop, ex_memread, ex_memwrite, ex_pc4, ex_rdata1, ex_rdata2, ex_imm,
           ex_rs, ex_rt, ex_rd, load_use_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_regdst, id_branch, id_memtoreg, id_alusrc, id_regwrite,
           id_jump, id_aluop, id_memread, id_memwrite, id_pc4, id_rdata1, id_rdata2, id_imm,
           id_rs, id_rt, id_rd,
    output ex_valid, ex_regdst, ex_branch, ex_memtoreg, ex_alusrc, ex_regwrite,
           ex_jump, ex_aluop, ex_memread, ex_memwrite, ex_pc4, ex_rdata1, ex_rdata2, ex_imm,
           ex_rs, ex_rt, ex_rd, load_use_stall
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall, flush and decoder-output sanitising.
// Define ID_EX_LOAD_USE_DETECT_EN to include the load-use hazard detector.
module id_ex_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  id_ex_pipe_reg_if.slave    bus
);

  typedef struct packed {
    logic                  valid;
    logic                  regdst;
    logic                  branch;
    logic                  memtoreg;
    logic                  alusrc;
    logic                  regwrite;
    logic [1:0]            jump;
    logic [1:0]            aluop;
    logic [1:0]            memread;
    logic [1:0]            memwrite;
    logic [DATA_W-1:0]     pc4;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } stage_t;

  stage_t q;
  stage_t d;
  stage_t load;
  logic   hazard;

  // Don't-care decoder outputs are forced to 0 so EX never sees stale or X control.
  always_comb begin
    load          = '0;
    load.valid    = 1'b1;
    load.regwrite = bus.id_regwrite;
    load.regdst   = bus.id_regwrite & bus.id_regdst;
    load.memtoreg = bus.id_regwrite & bus.id_memtoreg;
    load.branch   = bus.id_branch;
    load.jump     = bus.id_jump;
    load.aluop    = (bus.id_jump != 2'b00) ? 2'b00 : bus.id_aluop;
    load.alusrc   = (bus.id_jump != 2'b00) ? 1'b0  : bus.id_alusrc;
    load.memread  = bus.id_memread;
    load.memwrite = bus.id_memwrite;
    load.pc4      = bus.id_pc4;
    load.rdata1   = bus.id_rdata1;
    load.rdata2   = bus.id_rdata2;
    load.imm      = bus.id_imm;
    load.rs       = bus.id_rs;
    load.rt       = bus.id_rt;
    load.rd       = bus.id_rd;
  end

`ifdef ID_EX_LOAD_USE_DETECT_EN
  // A load in EX whose destination feeds the ID instruction cannot forward in time.
  assign hazard = q.valid & (q.memread != 2'b00) & q.regwrite & (q.rt != '0) &
                  ((q.rt == bus.id_rs) |
                   ((q.rt == bus.id_rt) & (~bus.id_alusrc | (bus.id_memwrite != 2'b00)))) &
                  bus.id_valid;
  assign bus.load_use_stall = hazard & ~reset;
`else
  assign hazard             = 1'b0;
  assign bus.load_use_stall = 1'b0;
`endif

  always_comb begin
    d = q;
    if (bus.flush) begin
      d = '0;
    end else if (bus.stall) begin
      d = q;
    end else if (hazard || !bus.id_valid) begin
      d = '0;
    end else begin
      d = load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign bus.ex_valid    = q.valid;
  assign bus.ex_regdst   = q.regdst;
  assign bus.ex_branch   = q.branch;
  assign bus.ex_memtoreg = q.memtoreg;
  assign bus.ex_alusrc   = q.alusrc;
  assign bus.ex_regwrite = q.regwrite;
  assign bus.ex_jump     = q.jump;
  assign bus.ex_aluop    = q.aluop;
  assign bus.ex_memread  = q.memread;
  assign bus.ex_memwrite = q.memwrite;
  assign bus.ex_pc4      = q.pc4;
  assign bus.ex_rdata1   = q.rdata1;
  assign bus.ex_rdata2   = q.rdata2;
  assign bus.ex_imm      = q.imm;
  assign bus.ex_rs       = q.rs;
  assign bus.ex_rt       = q.rt;
  assign bus.ex_rd       = q.rd;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed and random checks of id_ex_pipe_reg against a rule-level model.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid, regdst, branch, memtoreg, alusrc, regwrite;
    logic [1:0]  jump, aluop, memread, memwrite;
    logic [31:0] pc4, rdata1, rdata2, imm;
    logic [4:0]  rs, rt, rd;
  } fields_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  fields_t exp_ex = '0;

  id_ex_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic fields_t id_snapshot();
    fields_t f;
    f = '{valid: bus.id_valid, regdst: bus.id_regdst, branch: bus.id_branch,
          memtoreg: bus.id_memtoreg, alusrc: bus.id_alusrc, regwrite: bus.id_regwrite,
          jump: bus.id_jump, aluop: bus.id_aluop, memread: bus.id_memread,
          memwrite: bus.id_memwrite, pc4: bus.id_pc4, rdata1: bus.id_rdata1,
          rdata2: bus.id_rdata2, imm: bus.id_imm, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd};
    return f;
  endfunction

  function automatic logic model_hazard(input fields_t ex, input fields_t id);
`ifdef ID_EX_LOAD_USE_DETECT_EN
    bool_t_dummy: begin end
    if (!ex.valid || ex.memread == 2'd0 || !ex.regwrite || ex.rt == 5'd0 || !id.valid) return 1'b0;
    if (ex.rt == id.rs) return 1'b1;
    if (ex.rt == id.rt && (id.alusrc == 1'b0 || id.memwrite != 2'd0)) return 1'b1;
    return 1'b0;
`else
    return (ex.valid & ~ex.valid) | (id.valid & ~id.valid);
`endif
  endfunction

  // Next EX contents from the priority rules: flush, stall, hazard/invalid bubble, sanitised load.
  function automatic fields_t model_next(input fields_t cur, input fields_t id,
                                         input logic stl, input logic fl, input logic hz);
    fields_t n;
    if (fl) return '0;
    if (stl) return cur;
    if (hz || !id.valid) return '0;
    n = id;
    if (!id.regwrite) begin
      n.regdst   = 1'b0;
      n.memtoreg = 1'b0;
    end
    if (id.jump != 2'd0) begin
      n.aluop  = 2'd0;
      n.alusrc = 1'b0;
    end
    return n;
  endfunction

  task automatic check_ex();
    check("ex_valid",    32'(bus.ex_valid),    32'(exp_ex.valid));
    check("ex_regdst",   32'(bus.ex_regdst),   32'(exp_ex.regdst));
    check("ex_branch",   32'(bus.ex_branch),   32'(exp_ex.branch));
    check("ex_memtoreg", 32'(bus.ex_memtoreg), 32'(exp_ex.memtoreg));
    check("ex_alusrc",   32'(bus.ex_alusrc),   32'(exp_ex.alusrc));
    check("ex_regwrite", 32'(bus.ex_regwrite), 32'(exp_ex.regwrite));
    check("ex_jump",     32'(bus.ex_jump),     32'(exp_ex.jump));
    check("ex_aluop",    32'(bus.ex_aluop),    32'(exp_ex.aluop));
    check("ex_memread",  32'(bus.ex_memread),  32'(exp_ex.memread));
    check("ex_memwrite", 32'(bus.ex_memwrite), 32'(exp_ex.memwrite));
    check("ex_pc4",      bus.ex_pc4,           exp_ex.pc4);
    check("ex_rdata1",   bus.ex_rdata1,        exp_ex.rdata1);
    check("ex_rdata2",   bus.ex_rdata2,        exp_ex.rdata2);
    check("ex_imm",      bus.ex_imm,           exp_ex.imm);
    check("ex_rs",       32'(bus.ex_rs),       32'(exp_ex.rs));
    check("ex_rt",       32'(bus.ex_rt),       32'(exp_ex.rt));
    check("ex_rd",       32'(bus.ex_rd),       32'(exp_ex.rd));
  endtask

  // Called just after a falling edge with inputs already applied; returns after the next falling edge.
  task automatic tick();
    fields_t id;
    logic    hz;
    id = id_snapshot();
    hz = model_hazard(exp_ex, id);
    check("load_use_stall", 32'(bus.load_use_stall), 32'(hz));
    @(posedge clk);
    exp_ex = model_next(exp_ex, id, bus.stall, bus.flush, hz);
    #1;
    check_ex();
    @(negedge clk);
  endtask

  task automatic set_nop();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_regdst = 0; bus.id_branch = 0; bus.id_memtoreg = 0; bus.id_alusrc = 0;
    bus.id_regwrite = 0; bus.id_jump = 0; bus.id_aluop = 0; bus.id_memread = 0;
    bus.id_memwrite = 0; bus.id_pc4 = 0; bus.id_rdata1 = 0; bus.id_rdata2 = 0;
    bus.id_imm = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
  endtask

  task automatic set_rand();
    bus.id_valid    = ($urandom_range(0, 4) != 0);
    bus.id_regdst   = 1'($urandom);
    bus.id_branch   = 1'($urandom);
    bus.id_memtoreg = 1'($urandom);
    bus.id_alusrc   = 1'($urandom);
    bus.id_regwrite = 1'($urandom);
    bus.id_jump     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
    bus.id_aluop    = 2'($urandom);
    bus.id_memread  = 2'($urandom);
    bus.id_memwrite = 2'($urandom);
    bus.id_pc4      = $urandom;
    bus.id_rdata1   = $urandom;
    bus.id_rdata2   = $urandom;
    bus.id_imm      = $urandom;
    bus.id_rs       = 5'($urandom_range(0, 7));
    bus.id_rt       = 5'($urandom_range(0, 7));
    bus.id_rd       = 5'($urandom);
  endtask

  task automatic set_lw(input logic [4:0] rt);
    set_nop();
    bus.id_valid = 1; bus.id_regwrite = 1; bus.id_memtoreg = 1; bus.id_alusrc = 1;
    bus.id_memread = 2'b01; bus.id_rs = 5'd2; bus.id_rt = rt; bus.id_imm = 32'h10;
    bus.id_pc4 = 32'h104;
  endtask

  task automatic set_add(input logic [4:0] rs);
    set_nop();
    bus.id_valid = 1; bus.id_regwrite = 1; bus.id_regdst = 1; bus.id_aluop = 2'b10;
    bus.id_rs = rs; bus.id_rt = 5'd9; bus.id_rd = 5'd10; bus.id_pc4 = 32'h108;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_nop();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_ex = '0;
    check_ex();
    check("lus_in_reset", 32'(bus.load_use_stall), 32'd0);
    reset = 0;

    // R-type
    set_nop();
    bus.id_valid = 1; bus.id_regwrite = 1; bus.id_regdst = 1; bus.id_aluop = 2'b10;
    bus.id_rdata1 = 32'h11; bus.id_rdata2 = 32'h22; bus.id_rs = 5'd1; bus.id_rt = 5'd2;
    bus.id_rd = 5'd5;
    tick();
    check("rtype_regdst", 32'(bus.ex_regdst), 32'd1);
    check("rtype_rdata1", bus.ex_rdata1, 32'h11);
    check("rtype_rd",     32'(bus.ex_rd), 32'd5);
    check("rtype_valid",  32'(bus.ex_valid), 32'd1);

    // Store: regdst/memtoreg are don't-cares and must read 0
    set_nop();
    bus.id_valid = 1; bus.id_memwrite = 2'b01; bus.id_regdst = 1; bus.id_memtoreg = 1;
    bus.id_alusrc = 1; bus.id_rs = 5'd3; bus.id_rt = 5'd4;
    tick();
    check("sw_regdst",   32'(bus.ex_regdst), 32'd0);
    check("sw_memtoreg", 32'(bus.ex_memtoreg), 32'd0);
    check("sw_memwrite", 32'(bus.ex_memwrite), 32'd1);

    // Jump: aluop/alusrc forced to 0
    set_nop();
    bus.id_valid = 1; bus.id_jump = 2'b01; bus.id_aluop = 2'b11; bus.id_alusrc = 1;
    tick();
    check("j_aluop",  32'(bus.ex_aluop), 32'd0);
    check("j_alusrc", 32'(bus.ex_alusrc), 32'd0);

    // Reset asserted between edges clears immediately
    set_lw(5'd7);
    tick();
    check("lw_loaded", 32'(bus.ex_memread), 32'd1);
    reset = 1;
    #1;
    exp_ex = '0;
    check_ex();
    check("lus_mid_reset", 32'(bus.load_use_stall), 32'd0);
    #1;
    reset = 0;
    @(negedge clk);

    // Stall 3 cycles then flush with stall still high
    set_nop();
    bus.id_valid = 1; bus.id_regwrite = 1; bus.id_regdst = 1; bus.id_rdata1 = 32'h11;
    bus.id_rd = 5'd5;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_rand();
      bus.id_rs = 5'd20; bus.id_rt = 5'd21;
      bus.stall = 1;
      tick();
      check("stall_hold_rdata1", bus.ex_rdata1, 32'h11);
      check("stall_hold_valid", 32'(bus.ex_valid), 32'd1);
    end
    bus.flush = 1;
    tick();
    check("flush_valid", 32'(bus.ex_valid), 32'd0);
    check("flush_rdata1", bus.ex_rdata1, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_rand();
      bus.stall = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      tick();
    end

`ifdef ID_EX_LOAD_USE_DETECT_EN
    set_nop();
    tick();
    set_lw(5'd8);
    tick();
    set_add(5'd8);
    check("hz_lus_on", 32'(bus.load_use_stall), 32'd1);
    tick();
    check("hz_bubble", 32'(bus.ex_valid), 32'd0);
    check("hz_lus_off", 32'(bus.load_use_stall), 32'd0);
    tick();
    check("hz_add_valid", 32'(bus.ex_valid), 32'd1);
    check("hz_add_rs", 32'(bus.ex_rs), 32'd8);

    set_lw(5'd0);
    tick();
    set_add(5'd0);
    check("hz_rt0_lus", 32'(bus.load_use_stall), 32'd0);
    tick();
    check("hz_rt0_add", 32'(bus.ex_valid), 32'd1);

    set_lw(5'd8);
    tick();
    set_add(5'd8);
    bus.stall = 1;
    for (int i = 0; i < 2; i++) begin
      check("hzst_lus", 32'(bus.load_use_stall), 32'd1);
      tick();
      check("hzst_lw_held", 32'(bus.ex_memread), 32'd1);
    end
    bus.stall = 0;
    check("hzst_lus_release", 32'(bus.load_use_stall), 32'd1);
    tick();
    check("hzst_bubble", 32'(bus.ex_valid), 32'd0);
    tick();
    check("hzst_add", 32'(bus.ex_rd), 32'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
